// File: rtl/sdram_port_arbiter_pkg.sv
// Shared SDRAM constants and arbiter state type. The widths are also used by the SDRAM controller.
package sdram_pkg;
  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_BA_W   = 2;
  localparam int SDRAM_D_W    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    ACCEPT = 2'd2,
    BUSY   = 2'd3
  } arb_state_t;
endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester fabric and SDRAM controller signals seen by the port arbiter.
interface sdram_port_arbiter_if
  import sdram_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int ADDR_WIDTH = SDRAM_ADDR_W,
  parameter int BA_WIDTH   = SDRAM_BA_W,
  parameter int D_WIDTH    = SDRAM_D_W
) ();
  logic [N_PORTS-1:0]            i_req;
  logic [N_PORTS-1:0]            i_rw;
  logic [N_PORTS*ADDR_WIDTH-1:0] i_addr;
  logic [N_PORTS*BA_WIDTH-1:0]   i_ba;
  logic [N_PORTS*D_WIDTH-1:0]    i_wdata;
  logic [N_PORTS-1:0]            o_gnt;
  logic [N_PORTS-1:0]            o_done;
  logic [D_WIDTH-1:0]            o_rdata;
  logic                          o_ctl_initial;
  logic                          o_ctl_rw;
  logic [ADDR_WIDTH-1:0]         o_ctl_addr;
  logic [BA_WIDTH-1:0]           o_ctl_ba;
  logic [D_WIDTH-1:0]            o_ctl_data;
  logic                          i_ctl_busy;
  logic [D_WIDTH-1:0]            i_ctl_rdata;

  modport master (
    output i_req, i_rw, i_addr, i_ba, i_wdata, i_ctl_busy, i_ctl_rdata,
    input  o_gnt, o_done, o_rdata, o_ctl_initial, o_ctl_rw, o_ctl_addr, o_ctl_ba, o_ctl_data
  );

  modport slave (
    input  i_req, i_rw, i_addr, i_ba, i_wdata, i_ctl_busy, i_ctl_rdata,
    output o_gnt, o_done, o_rdata, o_ctl_initial, o_ctl_rw, o_ctl_addr, o_ctl_ba, o_ctl_data
  );
endinterface

// File: rtl/sdram_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping modulo N_PORTS.
module rr_arbiter #(
  parameter int N_PORTS = 4
) (
  input  logic [N_PORTS-1:0]         req,
  input  logic [$clog2(N_PORTS)-1:0] ptr,
  output logic [N_PORTS-1:0]         gnt,
  output logic [$clog2(N_PORTS)-1:0] idx,
  output logic                       vld
);
  localparam int PW = $clog2(N_PORTS);

  logic [PW-1:0] k;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    k   = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      k = PW'((int'(ptr) + i) % N_PORTS);
      if (!vld && req[k]) begin
        vld    = 1'b1;
        idx    = k;
        gnt[k] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one single-word SDRAM controller between N_PORTS requesters with round-robin
// arbitration, strobe re-issue on missing acknowledge, and done/read-data return to the winner.
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int N_PORTS     = 4,
  parameter int ADDR_WIDTH  = SDRAM_ADDR_W,
  parameter int BA_WIDTH    = SDRAM_BA_W,
  parameter int D_WIDTH     = SDRAM_D_W,
  parameter int ACK_TIMEOUT = 8
) (
  input logic                 CLK,
  input logic                 i_rst,
  sdram_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_PORTS);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ISSUE  = ISSUE;
  localparam logic [1:0] ST_ACCEPT = ACCEPT;
  localparam logic [1:0] ST_BUSY   = BUSY;

  logic [1:0]            state;
  logic [PW-1:0]         ptr;
  logic [N_PORTS-1:0]    win_oh;
  logic [CW-1:0]         cnt;
  logic [N_PORTS-1:0]    gnt_q;
  logic [N_PORTS-1:0]    done_q;
  logic                  init_q;
  logic [D_WIDTH-1:0]    rdata_q;
  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BA_WIDTH-1:0]   ba_q;
  logic [D_WIDTH-1:0]    data_q;

  logic [N_PORTS-1:0]    pick_gnt;
  logic [PW-1:0]         pick_idx;
  logic                  pick_vld;

  rr_arbiter #(.N_PORTS(N_PORTS)) u_rr (
    .req (bus.i_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_ff @(posedge CLK or negedge i_rst) begin
    if (!i_rst) begin
      state   <= ST_IDLE;
      ptr     <= PW'(N_PORTS - 1);
      win_oh  <= '0;
      cnt     <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      init_q  <= 1'b0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      ba_q    <= '0;
      data_q  <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      init_q <= 1'b0;
      case (state)
        // A refresh shows up as busy in IDLE and holds off any new grant.
        ST_IDLE: begin
          if (pick_vld && !bus.i_ctl_busy) begin
            gnt_q  <= pick_gnt;
            win_oh <= pick_gnt;
            ptr    <= pick_idx;
            rw_q   <= bus.i_rw[pick_idx];
            addr_q <= bus.i_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            ba_q   <= bus.i_ba[int'(pick_idx)*BA_WIDTH +: BA_WIDTH];
            data_q <= bus.i_wdata[int'(pick_idx)*D_WIDTH +: D_WIDTH];
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          init_q <= 1'b1;
          cnt    <= '0;
          state  <= ST_ACCEPT;
        end
        // No busy within ACK_TIMEOUT cycles: re-strobe the same captured command.
        ST_ACCEPT: begin
          if (bus.i_ctl_busy)                   state <= ST_BUSY;
          else if (cnt == CW'(ACK_TIMEOUT - 1)) state <= ST_ISSUE;
          else                                  cnt   <= cnt + 1'b1;
        end
        ST_BUSY: begin
          if (!bus.i_ctl_busy) begin
            done_q <= win_oh;
            if (!rw_q) rdata_q <= bus.i_ctl_rdata;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_gnt         = gnt_q;
  assign bus.o_done        = done_q;
  assign bus.o_rdata       = rdata_q;
  assign bus.o_ctl_initial = init_q;
  assign bus.o_ctl_rw      = rw_q;
  assign bus.o_ctl_addr    = addr_q;
  assign bus.o_ctl_ba      = ba_q;
  assign bus.o_ctl_data    = data_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a transaction-level reference model and a
// simple controller emulation that acknowledges strobes with a fixed-length busy burst.
module tb_sdram_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 23;
  localparam int BW = 2;
  localparam int DW = 16;
  localparam int TO = 8;

  logic CLK = 1'b0;
  logic i_rst;
  always #5 CLK = ~CLK;

  sdram_port_arbiter_if #(.N_PORTS(N), .ADDR_WIDTH(AW), .BA_WIDTH(BW), .D_WIDTH(DW)) bus ();

  sdram_port_arbiter #(
    .N_PORTS(N), .ADDR_WIDTH(AW), .BA_WIDTH(BW), .D_WIDTH(DW), .ACK_TIMEOUT(TO)
  ) dut (
    .CLK   (CLK),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Controller emulation: refresh forces busy; an accepted strobe gives 6 busy cycles.
  bit          refresh = 1'b0;
  int          ignore_strobes = 0;
  logic [DW-1:0] rd_word = '0;
  int          acc = 0;

  initial begin
    bus.i_ctl_busy  = 1'b0;
    bus.i_ctl_rdata = '0;
    forever begin
      @(posedge CLK); #2;
      if (!i_rst) acc = 0;
      else if (acc > 0) acc--;
      else if (bus.o_ctl_initial && ignore_strobes == 0) acc = 6;
      else if (bus.o_ctl_initial) ignore_strobes--;
      bus.i_ctl_busy  = refresh || (acc > 0);
      bus.i_ctl_rdata = rd_word;
    end
  end

  // Reference model: operations tracked by edge timestamps rather than controller states.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 1; i <= N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  int m_pick;
  int m_ptr, m_port, m_cyc, m_strobe;
  bit m_open, m_acked, m_rd;
  logic [N-1:0]  e_gnt, e_done;
  logic          e_init, e_rw;
  logic [AW-1:0] e_addr;
  logic [BW-1:0] e_ba;
  logic [DW-1:0] e_data, e_rdata;

  always_comb m_pick = pick(bus.i_req, m_ptr);

  always @(posedge CLK or negedge i_rst) begin
    if (!i_rst) begin
      m_open <= 1'b0; m_acked <= 1'b0; m_rd <= 1'b0; m_ptr <= N - 1; m_port <= 0;
      m_strobe <= 0; m_cyc <= 0;
      e_gnt <= '0; e_done <= '0; e_init <= 1'b0; e_rw <= 1'b0;
      e_addr <= '0; e_ba <= '0; e_data <= '0; e_rdata <= '0;
    end else begin
      m_cyc  <= m_cyc + 1;
      e_gnt  <= '0;
      e_done <= '0;
      e_init <= 1'b0;
      if (!m_open) begin
        if (m_pick >= 0 && !bus.i_ctl_busy) begin
          e_gnt    <= N'(1) << m_pick;
          m_port   <= m_pick;
          m_ptr    <= m_pick;
          m_open   <= 1'b1;
          m_acked  <= 1'b0;
          m_strobe <= m_cyc + 1;
          m_rd     <= !bus.i_rw[m_pick];
          e_rw     <= bus.i_rw[m_pick];
          e_addr   <= bus.i_addr[m_pick*AW +: AW];
          e_ba     <= bus.i_ba[m_pick*BW +: BW];
          e_data   <= bus.i_wdata[m_pick*DW +: DW];
        end
      end else if (m_cyc == m_strobe) begin
        e_init <= 1'b1;
      end else if (!m_acked) begin
        if (bus.i_ctl_busy) m_acked <= 1'b1;
        else if (m_cyc - m_strobe == TO) m_strobe <= m_cyc + 1;
      end else if (!bus.i_ctl_busy) begin
        e_done <= N'(1) << m_port;
        if (m_rd) e_rdata <= bus.i_ctl_rdata;
        m_open <= 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("gnt",     bus.o_gnt,         e_gnt);
      check("done",    bus.o_done,        e_done);
      check("initial", bus.o_ctl_initial, e_init);
      check("ctl_rw",  bus.o_ctl_rw,      e_rw);
      check("addr",    bus.o_ctl_addr,    e_addr);
      check("ba",      bus.o_ctl_ba,      e_ba);
      check("wdata",   bus.o_ctl_data,    e_data);
      check("rdata",   bus.o_rdata,       e_rdata);
    end
  end

  task automatic tick();
    @(posedge CLK); #2;
  endtask

  task automatic wait_gnt(input int max, output logic [N-1:0] g);
    g = '0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (bus.o_gnt != '0) begin g = bus.o_gnt; break; end
    end
  endtask

  task automatic wait_done(input int max, output logic [N-1:0] d);
    d = '0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (bus.o_done != '0) begin d = bus.o_done; break; end
    end
  endtask

  task automatic set_port(input int p, input logic rw, input logic [AW-1:0] a,
                          input logic [BW-1:0] b, input logic [DW-1:0] w);
    bus.i_rw[p]           = rw;
    bus.i_addr[p*AW +: AW] = a;
    bus.i_ba[p*BW +: BW]   = b;
    bus.i_wdata[p*DW +: DW] = w;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0]  g, d;
    logic [AW-1:0] a1;
    int            strobes, t1, t2, extra, zero_gnt;
    bit            saw;
    i_rst = 1'b0;
    bus.i_req = '0; bus.i_rw = '0; bus.i_addr = '0; bus.i_ba = '0; bus.i_wdata = '0;
    repeat (3) tick();
    chk_en = 1'b1;
    check("reset_outputs", {bus.o_gnt, bus.o_done, bus.o_ctl_initial, bus.o_ctl_addr, bus.o_rdata}, 64'd0);
    i_rst = 1'b1;
    tick();

    // T2 single read from port 2
    rd_word = 16'hBEEF;
    set_port(2, 1'b0, 23'h012345, 2'd1, 16'h0);
    bus.i_req = 4'b0100;
    wait_gnt(10, g);
    check("t2_gnt", g, 4'b0100);
    bus.i_req = '0;
    tick();
    check("t2_strobe", bus.o_ctl_initial, 1'b1);
    check("t2_addr", bus.o_ctl_addr, 23'h012345);
    check("t2_ba", bus.o_ctl_ba, 2'd1);
    wait_done(20, d);
    check("t2_done", d, 4'b0100);
    check("t2_rdata", bus.o_rdata, 16'hBEEF);

    // T1 reset in the middle of a busy access
    set_port(1, 1'b0, 23'h000777, 2'd2, 16'h0);
    bus.i_req = 4'b0010;
    wait_gnt(10, g);
    check("t1_gnt", g, 4'b0010);
    bus.i_req = '0;
    repeat (4) tick();
    check("t1_busy_before_reset", bus.i_ctl_busy, 1'b1);
    i_rst = 1'b0;
    #1;
    check("t1_async_clear", {bus.o_gnt, bus.o_done, bus.o_ctl_initial, bus.o_ctl_addr, bus.o_ctl_ba, bus.o_rdata}, 64'd0);
    repeat (2) tick();
    i_rst = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.o_done != '0) saw = 1'b1;
    end
    check("t1_no_done_after_reset", saw, 1'b0);

    // T3 round robin, all ports requesting continuously
    for (int p = 0; p < N; p++) set_port(p, 1'b0, AW'(24'h100 * (p + 1)), BW'(p), DW'(p));
    bus.i_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(30, g);
      check($sformatf("t3_order%0d", k), g, N'(1) << (k % N));
    end
    bus.i_req = '0;
    wait_done(20, d);
    check("t3_last_done", d, 4'b0001);

    // T4 refresh in IDLE blocks the grant
    refresh = 1'b1;
    repeat (2) tick();
    set_port(1, 1'b0, 23'h055AA0, 2'd3, 16'h0);
    bus.i_req = 4'b0010;
    zero_gnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.o_gnt != '0) zero_gnt++;
    end
    check("t4_no_gnt_during_refresh", zero_gnt, 0);
    refresh = 1'b0;
    wait_gnt(5, g);
    check("t4_gnt", g, 4'b0010);
    bus.i_req = '0;
    wait_done(20, d);
    check("t4_done", d, 4'b0010);

    // T5 controller ignores the first strobe
    ignore_strobes = 1;
    set_port(0, 1'b0, 23'h3ABCDE, 2'd2, 16'h0);
    bus.i_req = 4'b0001;
    wait_gnt(10, g);
    check("t5_gnt", g, 4'b0001);
    bus.i_req = '0;
    strobes = 0; t1 = 0; t2 = 0; extra = 0; a1 = '0; d = '0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (bus.o_gnt != '0) extra++;
      if (bus.o_ctl_initial) begin
        strobes++;
        if (strobes == 1) begin t1 = t; a1 = bus.o_ctl_addr; end
        else if (strobes == 2) t2 = t;
      end
      if (bus.o_done != '0) begin d = bus.o_done; break; end
    end
    check("t5_strobes", strobes, 2);
    check("t5_first_strobe", t1, 1);
    check("t5_restrobe_gap", t2 - t1, TO + 1);
    check("t5_same_addr", a1, 23'h3ABCDE);
    check("t5_single_gnt", extra, 0);
    check("t5_done", d, 4'b0001);

    // T6 write from port 3 leaves read data untouched
    rd_word = 16'h1234;
    set_port(3, 1'b1, 23'h7FFFFF, 2'd0, 16'hA5A5);
    bus.i_req = 4'b1000;
    wait_gnt(10, g);
    check("t6_gnt", g, 4'b1000);
    bus.i_req = '0;
    tick();
    check("t6_wdata", bus.o_ctl_data, 16'hA5A5);
    check("t6_rw", bus.o_ctl_rw, 1'b1);
    wait_done(20, d);
    check("t6_done", d, 4'b1000);
    check("t6_rdata_kept", bus.o_rdata, 16'hBEEF);

    repeat (3) tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
